// File: rtl/regfile_serial_gen.sv
// Bit-serial register file: each frame streams rs1/rs2 LSB-first over REG_WIDTH shift cycles
// while the serial result is shifted into rd. Includes write masking, optional hardwired r0 and a debug read port.
module regfile_serial_gen #(
    parameter int REG_WIDTH = 16,
    parameter int REG_COUNT = 16,
    parameter int ADDR_W    = $clog2(REG_COUNT),
    parameter bit ZERO_REG  = 1'b1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            rs1_addr,
    input  logic [ADDR_W-1:0]            rs2_addr,
    input  logic [ADDR_W-1:0]            rd_addr,
    input  logic                         shift_en,
    input  logic                         wr_bit,
    input  logic                         wr_en,
    output logic                         rs1_bit,
    output logic                         rs2_bit,
    output logic                         busy,
    output logic [$clog2(REG_WIDTH)-1:0] bit_idx,
    output logic                         last_bit,
    output logic                         frame_done,
    input  logic [ADDR_W-1:0]            dbg_addr,
    output logic [REG_WIDTH-1:0]         dbg_data
);

    localparam int IDX_W = $clog2(REG_WIDTH);

    typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [IDX_W-1:0]       r_bit_idx;
    logic [IDX_W-1:0]       w_idx_nxt;
    logic                   r_done;
    logic                   w_done_nxt;
    logic                   w_latch;
    logic [ADDR_W-1:0]      r_rs1;
    logic [ADDR_W-1:0]      r_rs2;
    logic [ADDR_W-1:0]      r_rd;
    logic [REG_WIDTH-1:0]   r_regs [REG_COUNT];

    logic                   w_shift;
    logic                   w_last;
    logic                   w_rs1_ok;
    logic                   w_rs2_ok;
    logic                   w_rd_ok;
    logic                   w_dbg_ok;

    // An address is live if it maps to a real register and is not the hardwired zero register.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < REG_COUNT) && !(ZERO_REG && (a == '0));
    endfunction

    assign w_shift  = (r_state == S_BUSY) && shift_en;
    assign w_last   = (r_bit_idx == IDX_W'(REG_WIDTH - 1));
    assign w_rs1_ok = addr_ok(r_rs1);
    assign w_rs2_ok = addr_ok(r_rs2);
    assign w_rd_ok  = addr_ok(r_rd);
    assign w_dbg_ok = addr_ok(dbg_addr);

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_bit_idx;
        w_done_nxt  = 1'b0;
        w_latch     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_BUSY;
                    w_idx_nxt   = '0;
                    w_latch     = 1'b1;
                end
            end
            S_BUSY: begin
                if (shift_en) begin
                    if (w_last) begin
                        w_state_nxt = S_IDLE;
                        w_idx_nxt   = '0;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_idx_nxt = r_bit_idx + IDX_W'(1);
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= S_IDLE;
            r_bit_idx <= '0;
            r_done    <= 1'b0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_rd      <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_bit_idx <= w_idx_nxt;
            r_done    <= w_done_nxt;
            if (w_latch) begin
                r_rs1 <= rs1_addr;
                r_rs2 <= rs2_addr;
                r_rd  <= rd_addr;
            end
        end
    end

    // rd takes priority over the source rotation so a register used as both is shifted once, with the new bit.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_shift) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                if (w_rd_ok && (r_rd == ADDR_W'(i))) begin
                    r_regs[i] <= {(wr_en ? wr_bit : r_regs[i][0]), r_regs[i][REG_WIDTH-1:1]};
                end else if ((w_rs1_ok && (r_rs1 == ADDR_W'(i))) ||
                             (w_rs2_ok && (r_rs2 == ADDR_W'(i)))) begin
                    r_regs[i] <= {r_regs[i][0], r_regs[i][REG_WIDTH-1:1]};
                end
            end
        end
    end

    assign busy       = (r_state == S_BUSY);
    assign bit_idx    = r_bit_idx;
    assign last_bit   = busy && w_last;
    assign frame_done = r_done;
    assign rs1_bit    = busy && w_rs1_ok && r_regs[r_rs1][0];
    assign rs2_bit    = busy && w_rs2_ok && r_regs[r_rs2][0];
    assign dbg_data   = w_dbg_ok ? r_regs[dbg_addr] : '0;

endmodule

// File: tb/tb_regfile_serial_gen.sv
// Directed bench for regfile_serial_gen: frame write/read, read-before-write, stall, mid-frame reset,
// ignored start while busy, hardwired r0 and per-bit write masking.
module tb_regfile_serial_gen;

    logic        clk;
    logic        rstn;
    logic        start;
    logic [3:0]  rs1_addr;
    logic [3:0]  rs2_addr;
    logic [3:0]  rd_addr;
    logic        shift_en;
    logic        wr_bit;
    logic        wr_en;
    logic        rs1_bit;
    logic        rs2_bit;
    logic        busy;
    logic [3:0]  bit_idx;
    logic        last_bit;
    logic        frame_done;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int          n_checks;
    int          n_fails;
    logic [15:0] s1_cap;
    logic [15:0] s2_cap;
    int          frame_cyc;

    regfile_serial_gen #(
        .REG_WIDTH(16),
        .REG_COUNT(16),
        .ZERO_REG (1'b1)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rd_addr   (rd_addr),
        .shift_en  (shift_en),
        .wr_bit    (wr_bit),
        .wr_en     (wr_en),
        .rs1_bit   (rs1_bit),
        .rs2_bit   (rs2_bit),
        .busy      (busy),
        .bit_idx   (bit_idx),
        .last_bit  (last_bit),
        .frame_done(frame_done),
        .dbg_addr  (dbg_addr),
        .dbg_data  (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dbg_check(input string tag, input logic [3:0] a, input logic [15:0] exp);
        dbg_addr = a;
        #1;
        check(tag, 32'(dbg_data), 32'(exp));
    endtask

    // One full frame. inv drives wr_bit = ~rs1_bit; stall_at freezes shifting for 5 cycles at that bit;
    // poke raises start with different addresses at bits 5 and 15 while busy.
    task automatic run_frame(input logic [3:0] a1, input logic [3:0] a2, input logic [3:0] ad,
                             input logic [15:0] wd, input logic [15:0] wm, input bit inv,
                             input int stall_at, input bit poke);
        logic held;
        rs1_addr = a1;
        rs2_addr = a2;
        rd_addr  = ad;
        start    = 1'b1;
        shift_en = 1'b0;
        tick();
        start     = 1'b0;
        frame_cyc = 1;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int b = 0; b < 16; b++) begin
            if (b == stall_at) begin
                shift_en = 1'b0;
                held     = rs1_bit;
                for (int k = 0; k < 5; k++) begin
                    tick();
                    frame_cyc++;
                    check("stall_idx", 32'(bit_idx), 32'(b));
                    check("stall_rs1", 32'(rs1_bit), 32'(held));
                    check("stall_done", 32'(frame_done), 32'd0);
                end
            end
            check("bit_idx", 32'(bit_idx), 32'(b));
            check("last_bit", 32'(last_bit), 32'(b == 15));
            shift_en  = 1'b1;
            wr_bit    = inv ? ~rs1_bit : wd[b];
            wr_en     = wm[b];
            s1_cap[b] = rs1_bit;
            s2_cap[b] = rs2_bit;
            if (poke && (b == 5 || b == 15)) begin
                start    = 1'b1;
                rs1_addr = 4'd1;
                rs2_addr = 4'd2;
                rd_addr  = 4'd9;
            end else begin
                start = 1'b0;
            end
            tick();
            frame_cyc++;
        end
        start    = 1'b0;
        shift_en = 1'b0;
        wr_en    = 1'b0;
        check("done_pulse", 32'(frame_done), 32'd1);
        check("busy_end", 32'(busy), 32'd0);
        check("rs1_idle", 32'(rs1_bit), 32'd0);
        tick();
        check("done_clear", 32'(frame_done), 32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rstn     = 1'b0;
        start    = 1'b0;
        rs1_addr = '0;
        rs2_addr = '0;
        rd_addr  = '0;
        shift_en = 1'b0;
        wr_bit   = 1'b0;
        wr_en    = 1'b0;
        dbg_addr = 4'd3;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_idx", 32'(bit_idx), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_dbg", 32'(dbg_data), 32'd0);
        tick();
        tick();
        rstn = 1'b1;
        tick();

        // Write r3 = A5C3, frame_done 17 cycles after start.
        run_frame(4'd0, 4'd0, 4'd3, 16'hA5C3, 16'hFFFF, 1'b0, -1, 1'b0);
        check("t1_latency", 32'(frame_cyc), 32'd17);
        dbg_check("t1_r3", 4'd3, 16'hA5C3);

        // Read r3 on both sources into r5 with writes masked off.
        run_frame(4'd3, 4'd3, 4'd5, 16'hFFFF, 16'h0000, 1'b0, -1, 1'b0);
        check("t2_rs1_stream", 32'(s1_cap), 32'h0000A5C3);
        check("t2_rs2_stream", 32'(s2_cap), 32'h0000A5C3);
        dbg_check("t2_r3", 4'd3, 16'hA5C3);
        dbg_check("t2_r5", 4'd5, 16'h0000);

        // rd == rs1: invert in place, reads see the old bits.
        run_frame(4'd3, 4'd0, 4'd3, 16'h0000, 16'hFFFF, 1'b1, -1, 1'b0);
        check("t3_rs1_old", 32'(s1_cap), 32'h0000A5C3);
        dbg_check("t3_r3", 4'd3, 16'h5A3C);

        // Stall 5 cycles at bit 7 while reading r6.
        run_frame(4'd0, 4'd0, 4'd6, 16'h1234, 16'hFFFF, 1'b0, -1, 1'b0);
        run_frame(4'd6, 4'd0, 4'd7, 16'h0000, 16'h0000, 1'b0, 7, 1'b0);
        check("t4_latency", 32'(frame_cyc), 32'd22);
        check("t4_stream", 32'(s1_cap), 32'h00001234);
        dbg_check("t4_r6", 4'd6, 16'h1234);

        // Start pulses while busy must not disturb the running frame.
        run_frame(4'd0, 4'd0, 4'd8, 16'hC0DE, 16'hFFFF, 1'b0, -1, 1'b1);
        dbg_check("t5_r8", 4'd8, 16'hC0DE);
        dbg_check("t5_r9", 4'd9, 16'h0000);

        // Mid-frame reset during a write to r4.
        run_frame(4'd0, 4'd0, 4'd4, 16'hBEEF, 16'hFFFF, 1'b0, -1, 1'b0);
        dbg_check("t5_r4_pre", 4'd4, 16'hBEEF);
        rd_addr  = 4'd4;
        start    = 1'b1;
        tick();
        start    = 1'b0;
        shift_en = 1'b1;
        wr_en    = 1'b1;
        wr_bit   = 1'b1;
        for (int b = 0; b < 9; b++) tick();
        check("t5_idx_pre", 32'(bit_idx), 32'd9);
        rstn = 1'b0;
        #1;
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_idx", 32'(bit_idx), 32'd0);
        dbg_check("t5_r4", 4'd4, 16'h0000);
        dbg_check("t5_r3", 4'd3, 16'h0000);
        shift_en = 1'b0;
        wr_en    = 1'b0;
        rstn     = 1'b1;
        tick();
        check("t5_idle", 32'(busy), 32'd0);

        // Hardwired r0 and per-bit write masking on r2.
        run_frame(4'd0, 4'd0, 4'd0, 16'hFFFF, 16'hFFFF, 1'b0, -1, 1'b0);
        dbg_check("t6_r0", 4'd0, 16'h0000);
        run_frame(4'd0, 4'd0, 4'd2, 16'h0F0F, 16'hFFFF, 1'b0, -1, 1'b0);
        run_frame(4'd0, 4'd2, 4'd2, 16'hFFFF, 16'h5555, 1'b0, -1, 1'b0);
        check("t6_rs1_r0", 32'(s1_cap), 32'h00000000);
        check("t6_rs2_r2", 32'(s2_cap), 32'h00000F0F);
        dbg_check("t6_r2_mask", 4'd2, 16'h5F5F);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
